// File: rtl/conv_pkg.sv
// Shared constants for the convolution address FSM and command sequencer:
// command codes, sequencer state encodings, default widths and timeout margin.
package conv_pkg;

  localparam int NB_IMAGE_DEF   = 10;
  localparam int NB_DATA_DEF    = 8;
  localparam int TIMEOUT_MARGIN = 16;

  typedef logic [1:0] cmd_t;
  typedef logic [2:0] state_t;

  localparam cmd_t CMD_NOP  = 2'b00;
  localparam cmd_t CMD_LOAD = 2'b01;
  localparam cmd_t CMD_RUN  = 2'b10;
  localparam cmd_t CMD_READ = 2'b11;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_RUN_START = 3'd2;
  localparam state_t ST_RUN_WAIT  = 3'd3;
  localparam state_t ST_READ      = 3'd4;
  localparam state_t ST_FINISH    = 3'd5;

  // RUN_WAIT cycles allowed before the watchdog gives up on i_EoP.
  function automatic int timeout_limit(input int nb_image);
    return (1 << nb_image) + TIMEOUT_MARGIN;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Host/address-FSM bundle of the convolution sequencer; the sequencer takes
// the slave side, the host/address FSM side (or a bench) takes the master side.
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int NB_IMAGE = NB_IMAGE_DEF,
  parameter int NB_DATA  = NB_DATA_DEF
);
  cmd_t                i_cmd;
  logic                i_cmd_valid;
  logic [NB_IMAGE-1:0] i_imgLength;
  logic [NB_DATA-1:0]  i_data;
  logic                i_data_valid;
  logic                i_EoP;
  logic                i_changeBlock;

  logic                o_valid;
  logic                o_SoP;
  logic [NB_IMAGE-1:0] o_imgLength;
  logic [NB_DATA-1:0]  o_data;
  logic                o_rd_strobe;
  logic                o_busy;
  logic                o_done;
  logic                o_error;
  logic [NB_IMAGE-1:0] o_pixCount;

  modport master (
    output i_cmd, i_cmd_valid, i_imgLength, i_data, i_data_valid, i_EoP, i_changeBlock,
    input  o_valid, o_SoP, o_imgLength, o_data, o_rd_strobe, o_busy, o_done, o_error,
           o_pixCount
  );

  modport slave (
    input  i_cmd, i_cmd_valid, i_imgLength, i_data, i_data_valid, i_EoP, i_changeBlock,
    output o_valid, o_SoP, o_imgLength, o_data, o_rd_strobe, o_busy, o_done, o_error,
           o_pixCount
  );

endinterface

// File: rtl/conv_watchdog.sv
// Cycle watchdog: counts while enabled, restarts when disabled or cleared,
// and flags expiry on the cycle the count reaches the terminal value.
module conv_watchdog #(
  parameter int W = 11
) (
  input  logic         i_CLK,
  input  logic         i_reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] tc_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || !en_i) cnt_d = '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // cnt_q holds the number of enabled cycles already elapsed before this one.
  assign expired_o = en_i && (cnt_q == tc_i - W'(1));

endmodule

// File: rtl/conv_sequencer.sv
// Command sequencer for the convolution engine (LOAD / RUN / READ).
// Define CONV_SEQ_TIMEOUT_EN to add a RUN_WAIT watchdog driving o_error.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int NB_IMAGE = NB_IMAGE_DEF,
  parameter int NB_DATA  = NB_DATA_DEF
) (
  input logic             i_CLK,
  input logic             i_reset,
  conv_sequencer_if.slave bus
);
  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                rd_strobe_q;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic [NB_IMAGE-1:0] len_q, len_d;
  logic [NB_IMAGE-1:0] pix_q, pix_d;
  logic                accept;
  logic                timeout;

  assign accept = (state_q == ST_IDLE) && bus.i_cmd_valid && (bus.i_cmd != CMD_NOP);

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    data_d  = data_q;
    len_d   = len_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d = bus.i_imgLength;
          pix_d = '0;
          case (bus.i_cmd)
            CMD_LOAD: state_d = ST_LOAD;
            CMD_RUN:  state_d = ST_RUN_START;
            default: begin
              // o_valid must already be high in the first READ cycle.
              state_d = ST_READ;
              valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (bus.i_data_valid) begin
          valid_d = 1'b1;
          data_d  = bus.i_data;
          pix_d   = pix_q + NB_IMAGE'(1);
        end
        if (bus.i_changeBlock) state_d = ST_FINISH;
      end
      ST_RUN_START: state_d = ST_RUN_WAIT;
      ST_RUN_WAIT: begin
        if (bus.i_EoP)    state_d = ST_FINISH;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (bus.i_changeBlock) state_d = ST_FINISH;
        else                   valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rd_strobe_q <= valid_q;
      data_q      <= data_d;
      len_q       <= len_d;
      pix_q       <= pix_d;
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam logic [NB_IMAGE:0] WD_TC = (NB_IMAGE + 1)'(timeout_limit(NB_IMAGE));

  logic wd_expired;
  logic error_q;

  conv_watchdog #(.W(NB_IMAGE + 1)) u_watchdog (
    .i_CLK     (i_CLK),
    .i_reset   (i_reset),
    .en_i      (state_q == ST_RUN_WAIT),
    .clr_i     (accept),
    .tc_i      (WD_TC),
    .expired_o (wd_expired)
  );

  assign timeout = wd_expired;

  // Sticky until the next accepted command; i_EoP on the expiry cycle wins.
  always_ff @(posedge i_CLK) begin
    if (i_reset || accept) error_q <= 1'b0;
    else if ((state_q == ST_RUN_WAIT) && !bus.i_EoP && wd_expired) error_q <= 1'b1;
  end

  assign bus.o_error = error_q;
`else
  assign timeout     = 1'b0;
  assign bus.o_error = 1'b0;
`endif

  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_imgLength = len_q;
  assign bus.o_pixCount  = pix_q;
  assign bus.o_rd_strobe = rd_strobe_q;
  assign bus.o_SoP       = (state_q == ST_RUN_START);
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: command table, LOAD scoreboard,
// RUN / READ / illegal-input / watchdog / reset sequences.
module tb_conv_sequencer;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if #(.NB_IMAGE(10), .NB_DATA(8)) bus();

  conv_sequencer #(.NB_IMAGE(10), .NB_DATA(8)) dut (
    .i_CLK   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    cmd_t       cmd;
    logic [9:0] len;
    logic       busy;
    logic       sop;
    logic       vld;
    logic [9:0] exp_len;
    int         done;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  bit         mon_load = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.o_done) done_cnt++;
    if (mon_load && bus.o_valid) begin
      if (exp_q.size() == 0) check("load_extra_valid", 32'(exp_q.size()), 32'(1));
      else                   check("load_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send_cmd(input cmd_t c, input logic [9:0] len);
    bus.i_cmd       = c;
    bus.i_imgLength = len;
    bus.i_cmd_valid = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic to_idle(input string name);
    bus.i_changeBlock = 1'b1;
    bus.i_EoP         = 1'b1;
    for (int k = 0; k < 8 && bus.o_busy; k++) tick();
    bus.i_changeBlock = 1'b0;
    bus.i_EoP         = 1'b0;
    check(name, 32'(bus.o_busy), 32'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 32'(bus.o_valid), 0);
    check({name, "_sop"},   32'(bus.o_SoP), 0);
    check({name, "_len"},   32'(bus.o_imgLength), 0);
    check({name, "_data"},  32'(bus.o_data), 0);
    check({name, "_rd"},    32'(bus.o_rd_strobe), 0);
    check({name, "_busy"},  32'(bus.o_busy), 0);
    check({name, "_done"},  32'(bus.o_done), 0);
    check({name, "_error"}, 32'(bus.o_error), 0);
    check({name, "_pix"},   32'(bus.o_pixCount), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "tb_conv_sequencer stalled");
  end

  initial begin
    int d0, vc, sc, mism, sop_seen, early;
    logic prev;

    bus.i_cmd = CMD_NOP; bus.i_cmd_valid = 1'b0; bus.i_imgLength = '0;
    bus.i_data = '0; bus.i_data_valid = 1'b0; bus.i_EoP = 1'b0; bus.i_changeBlock = 1'b0;

    tbl[0] = '{CMD_NOP,  10'd11, 1'b0, 1'b0, 1'b0, 10'd0,  0};
    tbl[1] = '{CMD_LOAD, 10'd33, 1'b1, 1'b0, 1'b0, 10'd33, 1};
    tbl[2] = '{CMD_RUN,  10'd44, 1'b1, 1'b1, 1'b0, 10'd44, 1};
    tbl[3] = '{CMD_READ, 10'd55, 1'b1, 1'b0, 1'b1, 10'd55, 1};
    tbl[4] = '{CMD_NOP,  10'd66, 1'b0, 1'b0, 1'b0, 10'd55, 0};

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Command decode table
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      send_cmd(tbl[i].cmd, tbl[i].len);
      check($sformatf("tbl%0d_busy", i),  32'(bus.o_busy),      32'(tbl[i].busy));
      check($sformatf("tbl%0d_sop", i),   32'(bus.o_SoP),       32'(tbl[i].sop));
      check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid),     32'(tbl[i].vld));
      check($sformatf("tbl%0d_len", i),   32'(bus.o_imgLength), 32'(tbl[i].exp_len));
      to_idle($sformatf("tbl%0d_idle", i));
      tick();
      check($sformatf("tbl%0d_done", i), 32'(done_cnt - d0), 32'(tbl[i].done));
    end

    // i_changeBlock / i_EoP in IDLE are ignored
    bus.i_changeBlock = 1'b1; bus.i_EoP = 1'b1;
    d0 = done_cnt;
    repeat (3) tick();
    bus.i_changeBlock = 1'b0; bus.i_EoP = 1'b0;
    check("idle_cb_busy", 32'(bus.o_busy), 0);
    check("idle_cb_done", 32'(done_cnt - d0), 0);

    // LOAD: 1024 pixels through the scoreboard, i_EoP ignored, last pixel with i_changeBlock
    mon_load = 1'b1;
    exp_q.delete();
    send_cmd(CMD_LOAD, 10'd1023);
    check("load_busy", 32'(bus.o_busy), 1);
    d0 = done_cnt;
    for (int i = 0; i < 1024; i++) begin
      if (i % 128 == 64) begin
        bus.i_data_valid = 1'b0;
        tick();
      end
      bus.i_data        = 8'(i);
      bus.i_data_valid  = 1'b1;
      bus.i_EoP         = (i >= 200 && i < 204);
      bus.i_changeBlock = (i == 1023);
      exp_q.push_back(8'(i));
      tick();
      if (i == 203) begin
        check("load_eop_busy", 32'(bus.o_busy), 1);
        check("load_eop_done", 32'(bus.o_done), 0);
      end
      if (i == 511) check("load_pixcount", 32'(bus.o_pixCount), 512);
    end
    bus.i_data_valid = 1'b0; bus.i_EoP = 1'b0; bus.i_changeBlock = 1'b0;
    check("load_q_drained", 32'(exp_q.size()), 0);
    check("load_last_valid", 32'(bus.o_valid), 1);
    check("load_finish_done", 32'(bus.o_done), 1);
    check("load_pix_wrap", 32'(bus.o_pixCount), 0);
    tick();
    check("load_idle_busy", 32'(bus.o_busy), 0);
    check("load_idle_valid", 32'(bus.o_valid), 0);
    repeat (3) tick();
    check("load_one_done", 32'(done_cnt - d0), 1);
    mon_load = 1'b0;

    // RUN: one-cycle SoP, illegal cmd / changeBlock ignored in RUN_WAIT, EoP at cycle 1030
    send_cmd(CMD_RUN, 10'd777);
    check("run_sop", 32'(bus.o_SoP), 1);
    check("run_valid0", 32'(bus.o_valid), 0);
    check("run_len", 32'(bus.o_imgLength), 777);
    tick();
    check("run_sop_single", 32'(bus.o_SoP), 0);
    sop_seen = 0; vc = 0; early = 0; d0 = done_cnt;
    for (int c = 2; c < 1030; c++) begin
      bus.i_cmd         = CMD_LOAD;
      bus.i_imgLength   = 10'd5;
      bus.i_cmd_valid   = (c >= 100 && c < 103);
      bus.i_changeBlock = (c >= 300 && c < 302);
      tick();
      sop_seen += int'(bus.o_SoP);
      vc       += int'(bus.o_valid);
      early    += int'(!bus.o_busy);
    end
    bus.i_cmd_valid = 1'b0; bus.i_changeBlock = 1'b0;
    check("run_no_sop", 32'(sop_seen), 0);
    check("run_no_valid", 32'(vc), 0);
    check("run_stayed_busy", 32'(early), 0);
    check("run_len_kept", 32'(bus.o_imgLength), 777);
    check("run_no_early_done", 32'(done_cnt - d0), 0);
    bus.i_EoP = 1'b1;
    tick();
    bus.i_EoP = 1'b0;
    check("run_done", 32'(bus.o_done), 1);
    tick();
    check("run_idle_busy", 32'(bus.o_busy), 0);
    check("run_idle_done", 32'(bus.o_done), 0);

    // READ: 1024 valid cycles, strobe trails by one cycle
    send_cmd(CMD_READ, 10'd1023);
    check("read_first_valid", 32'(bus.o_valid), 1);
    check("read_first_strobe", 32'(bus.o_rd_strobe), 0);
    vc = 1; sc = 0; mism = 0; prev = 1'b1;
    for (int j = 2; j <= 1028; j++) begin
      bus.i_changeBlock = (j == 1025);
      tick();
      if (bus.o_rd_strobe !== prev) mism++;
      vc += int'(bus.o_valid);
      sc += int'(bus.o_rd_strobe);
      prev = bus.o_valid;
      if (j == 1025) begin
        check("read_final_valid", 32'(bus.o_valid), 0);
        check("read_final_strobe", 32'(bus.o_rd_strobe), 1);
        check("read_done", 32'(bus.o_done), 1);
      end
    end
    bus.i_changeBlock = 1'b0;
    check("read_valid_cycles", 32'(vc), 1024);
    check("read_strobe_pulses", 32'(sc), 1024);
    check("read_strobe_trail", 32'(mism), 0);
    check("read_idle_busy", 32'(bus.o_busy), 0);

    // Watchdog: RUN without i_EoP
    send_cmd(CMD_RUN, 10'd9);
    d0 = done_cnt;
    for (int c = 0; c < 1040; c++) tick();
    check("wd_pre_busy", 32'(bus.o_busy), 1);
    check("wd_pre_err", 32'(bus.o_error), 0);
    tick();
`ifdef CONV_SEQ_TIMEOUT_EN
    check("wd_idle", 32'(bus.o_busy), 0);
    check("wd_err", 32'(bus.o_error), 1);
    check("wd_no_done", 32'(done_cnt - d0), 0);
    send_cmd(CMD_NOP, 10'd0);
    tick();
    check("wd_err_hold", 32'(bus.o_error), 1);
    send_cmd(CMD_LOAD, 10'd1);
    check("wd_err_cleared", 32'(bus.o_error), 0);
    to_idle("wd_exit");
`else
    check("wd_off_busy", 32'(bus.o_busy), 1);
    check("wd_off_err", 32'(bus.o_error), 0);
    repeat (200) tick();
    check("wd_off_still_busy", 32'(bus.o_busy), 1);
    check("wd_off_still_err", 32'(bus.o_error), 0);
    to_idle("wd_off_exit");
`endif

    // Reset at pixel 500 of LOAD
    mon_load = 1'b1;
    exp_q.delete();
    send_cmd(CMD_LOAD, 10'd600);
    for (int i = 0; i < 500; i++) begin
      bus.i_data = 8'(i);
      bus.i_data_valid = 1'b1;
      exp_q.push_back(8'(i));
      tick();
    end
    check("rst_q_drained", 32'(exp_q.size()), 0);
    d0 = done_cnt;
    mon_load = 1'b0;
    bus.i_data = 8'(500);
    rst = 1'b1;
    tick();
    check_all_zero("midload_rst");
    rst = 1'b0;
    bus.i_data_valid = 1'b0;
    repeat (3) tick();
    check("midload_rst_no_done", 32'(done_cnt - d0), 0);
    check("midload_rst_idle", 32'(bus.o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
